// File: rtl/fir_filter_top.sv
// 5-tap FIR accelerator: 1024x8 sample memory shared by a sequential engine and a
// 3-stage pipelined engine; y[n] = sat8((x[n]+..+x[n-4]) >>> 2) written to OUT_BASE+n.
module fir_filter_top #(
  parameter int unsigned NUM_SAMPLES = 64,
  parameter int unsigned OUT_BASE    = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel_pipelined,
  output logic       done,
  output logic [2:0] cycle_count
);
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 16;
  localparam int unsigned IW = 10;
  localparam int unsigned CW = 16;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SAMPLES - 1);
  localparam logic [AW-1:0] OUT_ADDR = AW'(OUT_BASE);

  typedef enum logic [3:0] {S_IDLE, S_RD_ADDR, S_RD_ACC, S_WRITE, S_DONE} seq_state_t;
  typedef enum logic [2:0] {P_IDLE, P_RUN, P_FLUSH, P_DONE} pipe_state_t;

  function automatic logic signed [DW-1:0] sat8(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> 2;
    if (sh > 16'sd127)       return 8'sh7F;
    else if (sh < -16'sd128) return 8'sh80;
    else                     return $signed(sh[DW-1:0]);
  endfunction

  // Dual-port sample memory (not reset)
  logic signed [DW-1:0] mem [0:1023];
  logic        [AW-1:0] addr_a, addr_b;
  logic                 we_a, we_b;
  logic signed [DW-1:0] data_in_a, data_in_b, data_out_a;

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_in_a;
    if (we_b) mem[addr_b] <= data_in_b;
    data_out_a <= mem[addr_a];
  end

  logic            start_q, sel_q, accept, go_seq, go_pipe;
  logic            seq_active, pipeline_active, seq_finish, pipe_finish;
  logic [CW-1:0]   cycle_counter;

  seq_state_t            seq_state, seq_next;
  logic [IW-1:0]         seq_n;
  logic [2:0]            seq_k;
  logic signed [SW-1:0]  seq_acc;
  logic [AW-1:0]         seq_addr, seq_waddr;
  logic                  seq_we;
  logic signed [DW-1:0]  seq_wdata;

  pipe_state_t           pipe_state, pipe_next;
  logic [IW-1:0]         read_sample_idx, write_sample_idx;
  logic                  rd_valid, valid_s1, output_valid_s3, pipe_issue;
  logic signed [DW-1:0]  x0_s1, x1_s1, x2_s1, x3_s1, x4_s1, result_s3;
  logic signed [SW-1:0]  sum_s2;
  logic [AW-1:0]         pipe_addr, pipe_waddr;
  logic                  pipe_we;
  logic signed [DW-1:0]  pipe_wdata;

  assign seq_active      = seq_state inside {S_RD_ADDR, S_RD_ACC, S_WRITE};
  assign pipeline_active = pipe_state inside {P_RUN, P_FLUSH};
  assign accept          = start & ~start_q & ~seq_active & ~pipeline_active;
  assign go_seq          = accept & ~sel_pipelined;
  assign go_pipe         = accept & sel_pipelined;
  assign cycle_count     = cycle_counter[2:0];

  // Run control: edge detect, engine latch, done flag and busy-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q       <= 1'b0;
      sel_q         <= 1'b0;
      done          <= 1'b0;
      cycle_counter <= '0;
    end else begin
      start_q <= start;
      if (accept) begin
        sel_q         <= sel_pipelined;
        done          <= 1'b0;
        cycle_counter <= '0;
      end else begin
        if (seq_active || pipeline_active) cycle_counter <= cycle_counter + CW'(1);
        if (seq_finish || pipe_finish)     done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seq_state <= S_IDLE;
    else     seq_state <= seq_next;
  end

  always_comb begin
    seq_next   = seq_state;
    seq_addr   = '0;
    seq_we     = 1'b0;
    seq_waddr  = '0;
    seq_wdata  = '0;
    seq_finish = 1'b0;
    case (seq_state)
      S_IDLE, S_DONE: seq_next = go_seq ? S_RD_ADDR : S_IDLE;
      S_RD_ADDR: begin
        seq_addr = AW'(seq_n) - AW'(seq_k);
        seq_next = S_RD_ACC;
      end
      S_RD_ACC: seq_next = (seq_k == 3'd4) ? S_WRITE : S_RD_ADDR;
      S_WRITE: begin
        seq_we    = 1'b1;
        seq_waddr = OUT_ADDR + AW'(seq_n);
        seq_wdata = sat8(seq_acc);
        if (seq_n == LAST_IDX) begin
          seq_next   = S_DONE;
          seq_finish = 1'b1;
        end else begin
          seq_next = S_RD_ADDR;
        end
      end
      default: seq_next = S_IDLE;
    endcase
  end

  // Taps with n-k < 0 read a wrapped address; their data is skipped
  always_ff @(posedge clk) begin
    if (rst || go_seq) begin
      seq_n   <= '0;
      seq_k   <= '0;
      seq_acc <= '0;
    end else begin
      case (seq_state)
        S_RD_ACC: begin
          if (seq_n >= IW'(seq_k)) seq_acc <= seq_acc + SW'(data_out_a);
          seq_k <= (seq_k == 3'd4) ? 3'd0 : seq_k + 3'd1;
        end
        S_WRITE: begin
          seq_acc <= '0;
          seq_n   <= seq_n + IW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_state <= P_IDLE;
    else     pipe_state <= pipe_next;
  end

  always_comb begin
    pipe_next   = pipe_state;
    pipe_addr   = '0;
    pipe_issue  = 1'b0;
    pipe_finish = 1'b0;
    case (pipe_state)
      P_IDLE, P_DONE: pipe_next = go_pipe ? P_RUN : P_IDLE;
      P_RUN: begin
        pipe_addr  = AW'(read_sample_idx);
        pipe_issue = 1'b1;
        if (read_sample_idx == LAST_IDX) pipe_next = P_FLUSH;
      end
      P_FLUSH: begin
        if (output_valid_s3 && write_sample_idx == LAST_IDX) begin
          pipe_next   = P_DONE;
          pipe_finish = 1'b1;
        end
      end
      default: pipe_next = P_IDLE;
    endcase
    pipe_we    = output_valid_s3;
    pipe_waddr = output_valid_s3 ? OUT_ADDR + AW'(write_sample_idx) : '0;
    pipe_wdata = output_valid_s3 ? result_s3 : '0;
  end

  assign sum_s2 = SW'(x0_s1) + SW'(x1_s1) + SW'(x2_s1) + SW'(x3_s1) + SW'(x4_s1);

  // Read -> tap shift (s1) -> sum/saturate into result_s3 -> write
  always_ff @(posedge clk) begin
    if (rst || go_pipe) begin
      read_sample_idx  <= '0;
      write_sample_idx <= '0;
      rd_valid         <= 1'b0;
      valid_s1         <= 1'b0;
      output_valid_s3  <= 1'b0;
      x0_s1            <= '0;
      x1_s1            <= '0;
      x2_s1            <= '0;
      x3_s1            <= '0;
      x4_s1            <= '0;
      result_s3        <= '0;
    end else begin
      rd_valid        <= pipe_issue;
      valid_s1        <= rd_valid;
      output_valid_s3 <= valid_s1;
      if (pipe_issue) read_sample_idx <= read_sample_idx + IW'(1);
      if (rd_valid) begin
        x0_s1 <= data_out_a;
        x1_s1 <= x0_s1;
        x2_s1 <= x1_s1;
        x3_s1 <= x2_s1;
        x4_s1 <= x3_s1;
      end
      if (valid_s1) result_s3 <= sat8(sum_s2);
      if (output_valid_s3) write_sample_idx <= write_sample_idx + IW'(1);
    end
  end

  // Only the latched engine reaches the memory; the other one idles at zero
  always_comb begin
    we_a      = 1'b0;
    data_in_a = '0;
    addr_a    = sel_q ? pipe_addr  : seq_addr;
    we_b      = sel_q ? pipe_we    : seq_we;
    addr_b    = sel_q ? pipe_waddr : seq_waddr;
    data_in_b = sel_q ? pipe_wdata : seq_wdata;
  end

endmodule

// File: tb/tb_fir_filter_top.sv
// Bench for fir_filter_top: table of runs, write scoreboard fed by a reference
// model, plus hand sequences for held start, mid-run reset and back-to-back runs.
module tb_fir_filter_top;
  localparam int N  = 64;
  localparam int OB = 512;

  logic       clk = 1'b0;
  logic       rst, start, sel_pipelined, done;
  logic [2:0] cycle_count;

  always #5 clk = ~clk;

  fir_filter_top #(.NUM_SAMPLES(N), .OUT_BASE(OB)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .sel_pipelined (sel_pipelined),
    .done          (done),
    .cycle_count   (cycle_count)
  );

  typedef struct { logic [9:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic sel; int kind; int exp_cnt; logic [2:0] exp_cc; } vec_t;

  wr_t        exp_q [$];
  wr_t        mon_e;
  logic [7:0] pat [0:N-1];
  int         n_cmp = 0, n_bad = 0, tb_cyc = 0, last_wr_cyc = 0;
  int         spec_y [0:10] = '{16, 32, 48, 64, 80, 64, 48, 32, 16, 0, 8};
  vec_t       vecs [0:6];

  logic       ld_en = 1'b0;
  logic [9:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  // Backdoor preload of input samples while the DUT is idle
  always @(posedge clk) if (ld_en) dut.mem[ld_addr] <= ld_data;
  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every DUT write must match the next expected y in order
  always @(negedge clk) begin
    if (!rst && dut.we_b) begin
      last_wr_cyc = tb_cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got write addr %0d data %0d, required none",
                 dut.addr_b, $signed(dut.data_in_b));
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", int'(dut.addr_b), int'(mon_e.addr));
        check("wr_data", int'($signed(dut.data_in_b)), int'($signed(mon_e.data)));
      end
    end
  end

  function automatic logic [7:0] model_y(input int n);
    int s;
    s = 0;
    for (int k = 0; k < 5; k++)
      if (n - k >= 0) s += int'($signed(pat[n-k]));
    s = s >>> 2;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic load_pattern(input int kind);
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       pat[i] = (i < 5) ? 8'd64 : ((i >= 10 && i < 15) ? 8'd32 : 8'd0);
        1:       pat[i] = 8'h7F;
        2:       pat[i] = 8'h80;
        default: pat[i] = 8'($urandom_range(0, 255));
      endcase
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 10'(i);
      ld_data = pat[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic queue_expected();
    wr_t e;
    for (int n = 0; n < N; n++) begin
      e.addr = 10'(OB + n);
      e.data = model_y(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(output bit ok);
    for (int c = 0; c < 2000 && !done; c++) @(negedge clk);
    ok = done;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done=0 after 2000 cycles, required done=1");
    end
  endtask

  task automatic do_run(input logic s, input int kind, input int exp_cnt, input logic [2:0] exp_cc);
    bit ok;
    load_pattern(kind);
    queue_expected();
    @(negedge clk);
    sel_pipelined = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_done_clear", int'(done), 0);
    check("accept_counter_clear", int'(dut.cycle_counter), 0);
    wait_done(ok);
    if (ok) check("done_latency", tb_cyc - last_wr_cyc, 1);
    check("cycle_counter", int'(dut.cycle_counter), exp_cnt);
    check("cycle_count", int'(cycle_count), int'(exp_cc));
    check("pending_writes", exp_q.size(), 0);
    if (kind == 0) begin
      for (int i = 0; i <= 10; i++) check("spec_y", int'($signed(dut.mem[OB+i])), spec_y[i]);
      check("spec_y14", int'($signed(dut.mem[OB+14])), 40);
    end else if (kind == 1 || kind == 2) begin
      for (int n = 4; n < N; n++)
        check("sat_y", int'($signed(dut.mem[OB+n])), (kind == 1) ? 127 : -128);
    end
    repeat (5) @(negedge clk);
    check("counter_frozen", int'(dut.cycle_counter), exp_cnt);
    check("done_held", int'(done), 1);
  endtask

  initial begin
    bit ok;
    vecs[0] = '{1'b0, 0, 704, 3'd0};
    vecs[1] = '{1'b1, 0, 67,  3'd3};
    vecs[2] = '{1'b0, 1, 704, 3'd0};
    vecs[3] = '{1'b1, 2, 67,  3'd3};
    vecs[4] = '{1'b1, 1, 67,  3'd3};
    vecs[5] = '{1'b0, 2, 704, 3'd0};
    vecs[6] = '{1'b1, 3, 67,  3'd3};

    rst = 1'b1;
    start = 1'b0;
    sel_pipelined = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_done", int'(done), 0);
    check("reset_cycle_count", int'(cycle_count), 0);
    check("reset_counter", int'(dut.cycle_counter), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      do_run(vecs[v].sel, vecs[v].kind, vecs[v].exp_cnt, vecs[v].exp_cc);

    // Held start, sel toggled and a second edge mid-run: one pipelined run only
    load_pattern(3);
    queue_expected();
    @(negedge clk);
    sel_pipelined = 1'b1;
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    sel_pipelined = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    check("hold_counter", int'(dut.cycle_counter), 67);
    check("hold_cycle_count", int'(cycle_count), 3);
    check("hold_pending", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    check("hold_done_held", int'(done), 1);
    check("hold_counter_frozen", int'(dut.cycle_counter), 67);

    // Reset in the middle of a sequential run, then a clean run
    load_pattern(0);
    queue_expected();
    @(negedge clk);
    sel_pipelined = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_done", int'(done), 0);
    check("midrst_cycle_count", int'(cycle_count), 0);
    check("midrst_counter", int'(dut.cycle_counter), 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("post_rst_idle_counter", int'(dut.cycle_counter), 0);
    check("post_rst_idle_done", int'(done), 0);
    do_run(1'b1, 0, 67, 3'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no summary by time limit, required run to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
